alu_arbiter: RTL and testbench
==============================

ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 Parameter REG_SIZE, default 8, operand and result width.
REQ-002 Parameter SEL_SIZE, default 3, ALU opcode width.
REQ-003 Parameter LAT_FAST, default 2, cycles held for opcodes 000/010/011 (mov, and, or).
REQ-004 Parameter LAT_SLOW, default 3, cycles held for opcodes 001/100/101/110/111.
REQ-005 CLK  in  1  sole clock; all state updates on rising edge.
REQ-006 RESET  in  1  reset, asynchronous, active-low.
REQ-007 REQ0_VALID, REQ1_VALID  in  1 each  requester n has an operation pending.
REQ-008 REQ0_READY, REQ1_READY  out  1 each  arbiter accepts requester n this cycle.
REQ-009 REQ0_SELECT, REQ1_SELECT  in  SEL_SIZE each  requested ALU opcode.
REQ-010 REQ0_DATA1/DATA2, REQ1_DATA1/DATA2  in  REG_SIZE each  operands.
REQ-011 RSP0_VALID, RSP1_VALID  out  1 each  one-cycle response pulse to requester n.
REQ-012 RSP_RESULT  out  REG_SIZE  captured ALU result (shared, qualified by RSPn_VALID).
REQ-013 RSP_ZERO  out  1  captured ALU ZERO flag.
REQ-014 ALU_DATA1, ALU_DATA2  out  REG_SIZE; ALU_SELECT  out  SEL_SIZE  registered drive to the shared ALU.
REQ-015 ALU_RESULT  in  REG_SIZE; ALU_ZERO  in  1  from the shared ALU.
REQ-016 BUSY  out  1  high while an operation is executing.

Function
REQ-017 FSM states IDLE and EXEC; BUSY = (state == EXEC).
REQ-018 In IDLE, READYn is combinational: REQn_VALID and grant to n; at most one READY high; both READY low in EXEC.
REQ-019 Grant: only one VALID -> that requester; both VALID -> the requester not in LAST_GRANT (round-robin).
REQ-020 Acceptance = VALIDn && READYn at edge k: latch owner into OWNER and LAST_GRANT, latch opcode/operands into ALU_SELECT/ALU_DATA1/ALU_DATA2, load down-counter with LAT_FAST or LAT_SLOW by opcode, go to EXEC.
REQ-021 ALU_* outputs stay constant throughout EXEC and hold last values in IDLE (no toggling without acceptance).
REQ-022 Counter decrements each EXEC cycle; at edge k+LAT, capture ALU_RESULT->RSP_RESULT and ALU_ZERO->RSP_ZERO, assert RSP<OWNER>_VALID for exactly one cycle, return to IDLE.
REQ-023 Earliest next acceptance is edge k+LAT+1; a single requester held valid is served once every LAT+1 cycles.
REQ-024 RSP_RESULT/RSP_ZERO hold their values until the next capture.
REQ-025 VALID deasserted before acceptance cancels the request with no side effect; operands are sampled only at the acceptance edge.
REQ-026 RSP0_VALID and RSP1_VALID are never high together.

Reset
REQ-027 RESET low, at any time including mid-EXEC: state IDLE, counter 0, OWNER 0, LAST_GRANT 1 (requester 0 wins first tie), all ALU_*, RSP_*, RSPn_VALID, BUSY 0; an in-flight operation is dropped without a response.
REQ-028 First acceptance is permitted at the first rising edge after RESET goes high.

Verification
REQ-029 After reset, REQ0 ADD (001) 5,3 held valid -> REQ0_READY 1 one cycle, ALU_SELECT 001, RSP0_VALID pulse 3 cycles after acceptance, RSP_RESULT 8, RSP_ZERO 0.
REQ-030 REQ1 AND (010) 0xF0,0x3C -> RSP1_VALID 2 cycles after acceptance, RSP_RESULT 0x30.
REQ-031 REQ0 ADD 5,0xFB -> RSP_RESULT 0x00, RSP_ZERO 1.
REQ-032 Both VALID continuously after reset -> grants 0,1,0,1; no simultaneous READY or RSP_VALID; ALU_* stable during every EXEC.
REQ-033 RESET low 1 cycle after acceptance of MULT (100) -> no RSP pulse, all outputs 0, new request accepted on first edge after release.
REQ-034 REQ1 alone, continuously valid with SELECT 101 -> acceptances every 4 cycles, BUSY low exactly one cycle between operations.

Source files
------------

// File: rtl/alu_arbiter_if.sv
// Requester handshakes, shared response bus and shared-ALU drive for alu_arbiter.
// Signal prefixes are from the arbiter's point of view (i_ = into the arbiter).
interface alu_arbiter_if #(
  parameter int REG_SIZE = 8,
  parameter int SEL_SIZE = 3
);
  logic                i_req0_valid;
  logic                i_req1_valid;
  logic                o_req0_ready;
  logic                o_req1_ready;
  logic [SEL_SIZE-1:0] i_req0_select;
  logic [SEL_SIZE-1:0] i_req1_select;
  logic [REG_SIZE-1:0] i_req0_data1;
  logic [REG_SIZE-1:0] i_req0_data2;
  logic [REG_SIZE-1:0] i_req1_data1;
  logic [REG_SIZE-1:0] i_req1_data2;

  logic                o_rsp0_valid;
  logic                o_rsp1_valid;
  logic [REG_SIZE-1:0] o_rsp_result;
  logic                o_rsp_zero;

  logic [REG_SIZE-1:0] o_alu_data1;
  logic [REG_SIZE-1:0] o_alu_data2;
  logic [SEL_SIZE-1:0] o_alu_select;
  logic [REG_SIZE-1:0] i_alu_result;
  logic                i_alu_zero;

  logic                o_busy;

  modport slave (
    input  i_req0_valid, i_req1_valid,
    input  i_req0_select, i_req1_select,
    input  i_req0_data1, i_req0_data2, i_req1_data1, i_req1_data2,
    input  i_alu_result, i_alu_zero,
    output o_req0_ready, o_req1_ready,
    output o_rsp0_valid, o_rsp1_valid, o_rsp_result, o_rsp_zero,
    output o_alu_data1, o_alu_data2, o_alu_select,
    output o_busy
  );

  modport master (
    output i_req0_valid, i_req1_valid,
    output i_req0_select, i_req1_select,
    output i_req0_data1, i_req0_data2, i_req1_data1, i_req1_data2,
    output i_alu_result, i_alu_zero,
    input  o_req0_ready, o_req1_ready,
    input  o_rsp0_valid, o_rsp1_valid, o_rsp_result, o_rsp_zero,
    input  o_alu_data1, o_alu_data2, o_alu_select,
    input  o_busy
  );
endinterface

// File: rtl/alu_arbiter.sv
// Two-requester round-robin arbiter in front of a shared, externally computed ALU.
// state | meaning
// IDLE  | waiting for a request; READY is combinational from VALID and the grant
// EXEC  | operands held on the ALU, latency counter running down to the capture edge
module alu_arbiter #(
  parameter int REG_SIZE = 8,
  parameter int SEL_SIZE = 3,
  parameter int LAT_FAST = 2,
  parameter int LAT_SLOW = 3
) (
  input logic          i_clk,
  input logic          i_rst_n,
  alu_arbiter_if.slave arb
);
  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_EXEC = 1'b1;

  localparam int LAT_MAX = (LAT_FAST > LAT_SLOW) ? LAT_FAST : LAT_SLOW;
  localparam int CNT_W   = $clog2(LAT_MAX + 1);
  localparam logic [CNT_W-1:0] CNT_FAST = CNT_W'(LAT_FAST);
  localparam logic [CNT_W-1:0] CNT_SLOW = CNT_W'(LAT_SLOW);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(1);

  logic [0:0]          r_state;
  logic [CNT_W-1:0]    r_cnt;
  logic                r_owner;
  logic                r_last_grant;
  logic [SEL_SIZE-1:0] r_alu_select;
  logic [REG_SIZE-1:0] r_alu_data1;
  logic [REG_SIZE-1:0] r_alu_data2;
  logic [REG_SIZE-1:0] r_rsp_result;
  logic                r_rsp_zero;
  logic                r_rsp0_valid;
  logic                r_rsp1_valid;

  logic                w_idle;
  logic                w_grant;
  logic                w_ready0;
  logic                w_ready1;
  logic                w_accept;
  logic                w_fast;
  logic [SEL_SIZE-1:0] w_sel;
  logic [REG_SIZE-1:0] w_d1;
  logic [REG_SIZE-1:0] w_d2;
  logic [CNT_W-1:0]    w_lat;

  assign w_idle = (r_state == ST_IDLE);

  // On a tie the requester that did not win last time is granted.
  always_comb begin
    w_grant = 1'b0;
    if (arb.i_req0_valid && arb.i_req1_valid) begin
      w_grant = ~r_last_grant;
    end else if (arb.i_req1_valid) begin
      w_grant = 1'b1;
    end
  end

  assign w_ready0 = w_idle && arb.i_req0_valid && !w_grant;
  assign w_ready1 = w_idle && arb.i_req1_valid &&  w_grant;
  assign w_accept = w_ready0 || w_ready1;

  assign w_sel = w_grant ? arb.i_req1_select : arb.i_req0_select;
  assign w_d1  = w_grant ? arb.i_req1_data1  : arb.i_req0_data1;
  assign w_d2  = w_grant ? arb.i_req1_data2  : arb.i_req0_data2;

  // mov, and, or complete on the fast path; everything else is slow.
  assign w_fast = (w_sel == SEL_SIZE'(0)) || (w_sel == SEL_SIZE'(2)) ||
                  (w_sel == SEL_SIZE'(3));
  assign w_lat  = w_fast ? CNT_FAST : CNT_SLOW;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state      <= ST_IDLE;
      r_cnt        <= '0;
      r_owner      <= 1'b0;
      r_last_grant <= 1'b1;
      r_alu_select <= '0;
      r_alu_data1  <= '0;
      r_alu_data2  <= '0;
      r_rsp_result <= '0;
      r_rsp_zero   <= 1'b0;
      r_rsp0_valid <= 1'b0;
      r_rsp1_valid <= 1'b0;
    end else begin
      r_rsp0_valid <= 1'b0;
      r_rsp1_valid <= 1'b0;
      if (r_state == ST_IDLE) begin
        if (w_accept) begin
          r_owner      <= w_grant;
          r_last_grant <= w_grant;
          r_alu_select <= w_sel;
          r_alu_data1  <= w_d1;
          r_alu_data2  <= w_d2;
          r_cnt        <= w_lat;
          r_state      <= ST_EXEC;
        end
      end else begin
        r_cnt <= r_cnt - CNT_LAST;
        // Terminal count: the ALU has had the full latency to settle.
        if (r_cnt == CNT_LAST) begin
          r_rsp_result <= arb.i_alu_result;
          r_rsp_zero   <= arb.i_alu_zero;
          r_rsp0_valid <= ~r_owner;
          r_rsp1_valid <= r_owner;
          r_state      <= ST_IDLE;
        end
      end
    end
  end

  assign arb.o_req0_ready = w_ready0;
  assign arb.o_req1_ready = w_ready1;
  assign arb.o_rsp0_valid = r_rsp0_valid;
  assign arb.o_rsp1_valid = r_rsp1_valid;
  assign arb.o_rsp_result = r_rsp_result;
  assign arb.o_rsp_zero   = r_rsp_zero;
  assign arb.o_alu_select = r_alu_select;
  assign arb.o_alu_data1  = r_alu_data1;
  assign arb.o_alu_data2  = r_alu_data2;
  assign arb.o_busy       = (r_state == ST_EXEC);
endmodule

// File: tb/tb_alu_arbiter.sv
// Self-checking bench for alu_arbiter: directed vector table, corner-case sequences,
// and randomized traffic checked against a transaction-timing reference model.
module tb_alu_arbiter;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  alu_arbiter_if #(.REG_SIZE(8), .SEL_SIZE(3)) bus ();

  alu_arbiter #(.REG_SIZE(8), .SEL_SIZE(3), .LAT_FAST(2), .LAT_SLOW(3)) dut (
    .i_clk  (clk),
    .i_rst_n(rst_n),
    .arb    (bus)
  );

  function automatic logic [7:0] alu_fn(input logic [2:0] op, input logic [7:0] a,
                                        input logic [7:0] b);
    logic [15:0] p;
    p = 16'(a) * 16'(b);
    case (op)
      3'b000:  return a;
      3'b001:  return a + b;
      3'b010:  return a & b;
      3'b011:  return a | b;
      3'b100:  return p[7:0];
      3'b101:  return a - b;
      3'b110:  return a ^ b;
      default: return ~(a | b);
    endcase
  endfunction

  function automatic int lat_of(input logic [2:0] op);
    return (op == 3'd0 || op == 3'd2 || op == 3'd3) ? 2 : 3;
  endfunction

  assign bus.i_alu_result = alu_fn(bus.o_alu_select, bus.o_alu_data1, bus.o_alu_data2);
  assign bus.i_alu_zero   = (bus.i_alu_result == 8'h00);

  int checks = 0;
  int errors = 0;

  // Reference model: edge index n counts rising edges since reset release.
  int         n, cur_n, next_free, pulse_at;
  bit         pend, pend_owner, pend_zero, last_g;
  logic [7:0] pend_res;
  logic [2:0] e_sel;
  logic [7:0] e_d1, e_d2, e_res;
  bit         e_zero, e_v0, e_v1;
  bit         acc0, acc1, obs_v0, obs_v1, obs_zero, obs_busy;
  logic [7:0] obs_res;

  typedef struct {
    bit         who;
    logic [2:0] sel;
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] res;
    bit         zero;
    int         lat;
  } vec_t;
  vec_t vecs[6];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h at edge %0d", nm, act, exp, n);
    end
  endtask

  task automatic model_reset();
    n = 0; next_free = 0; pulse_at = 0;
    pend = 0; pend_owner = 0; pend_zero = 0; pend_res = '0; last_g = 1;
    e_sel = '0; e_d1 = '0; e_d2 = '0; e_res = '0; e_zero = 0; e_v0 = 0; e_v1 = 0;
  endtask

  task automatic drive_idle();
    bus.i_req0_valid  = 1'b0;
    bus.i_req1_valid  = 1'b0;
    bus.i_req0_select = 3'($urandom_range(0, 7));
    bus.i_req1_select = 3'($urandom_range(0, 7));
    bus.i_req0_data1  = 8'($urandom);
    bus.i_req0_data2  = 8'($urandom);
    bus.i_req1_data1  = 8'($urandom);
    bus.i_req1_data2  = 8'($urandom);
  endtask

  task automatic drive_req(input bit who, input logic [2:0] sel, input logic [7:0] a,
                           input logic [7:0] b);
    if (!who) begin
      bus.i_req0_valid = 1'b1; bus.i_req0_select = sel;
      bus.i_req0_data1 = a;    bus.i_req0_data2  = b;
    end else begin
      bus.i_req1_valid = 1'b1; bus.i_req1_select = sel;
      bus.i_req1_data1 = a;    bus.i_req1_data2  = b;
    end
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_busy"}, 32'(bus.o_busy), 0);
    chk({tag, "_rsp0"}, 32'(bus.o_rsp0_valid), 0);
    chk({tag, "_rsp1"}, 32'(bus.o_rsp1_valid), 0);
    chk({tag, "_res"},  32'(bus.o_rsp_result), 0);
    chk({tag, "_zero"}, 32'(bus.o_rsp_zero), 0);
    chk({tag, "_sel"},  32'(bus.o_alu_select), 0);
    chk({tag, "_d1"},   32'(bus.o_alu_data1), 0);
    chk({tag, "_d2"},   32'(bus.o_alu_data2), 0);
  endtask

  task automatic do_reset();
    drive_idle();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk_zero("reset");
    model_reset();
    rst_n = 1'b1;
  endtask

  // One clock: compare at the falling edge, advance the model, then step past the rising edge.
  task automatic cycle();
    bit v0, v1, free, g, r0e, r1e;
    logic [2:0] s;
    logic [7:0] a, b;
    @(negedge clk);
    cur_n = n;
    v0 = bus.i_req0_valid;
    v1 = bus.i_req1_valid;
    e_v0 = 0; e_v1 = 0;
    if (pend && n == pulse_at) begin
      e_res = pend_res; e_zero = pend_zero;
      if (pend_owner) e_v1 = 1; else e_v0 = 1;
      pend = 0;
    end
    free = (n >= next_free);
    g    = (v0 && v1) ? ~last_g : v1;
    r0e  = free && v0 && !g;
    r1e  = free && v1 && g;
    obs_v0 = bus.o_rsp0_valid; obs_v1 = bus.o_rsp1_valid;
    obs_res = bus.o_rsp_result; obs_zero = bus.o_rsp_zero; obs_busy = bus.o_busy;
    acc0 = bus.o_req0_ready; acc1 = bus.o_req1_ready;
    chk("busy",   32'(bus.o_busy), 32'(!free));
    chk("ready0", 32'(bus.o_req0_ready), 32'(r0e));
    chk("ready1", 32'(bus.o_req1_ready), 32'(r1e));
    chk("rsp0_v", 32'(bus.o_rsp0_valid), 32'(e_v0));
    chk("rsp1_v", 32'(bus.o_rsp1_valid), 32'(e_v1));
    chk("rsp_res",  32'(bus.o_rsp_result), 32'(e_res));
    chk("rsp_zero", 32'(bus.o_rsp_zero), 32'(e_zero));
    chk("alu_sel",  32'(bus.o_alu_select), 32'(e_sel));
    chk("alu_d1",   32'(bus.o_alu_data1), 32'(e_d1));
    chk("alu_d2",   32'(bus.o_alu_data2), 32'(e_d2));
    if (r0e || r1e) begin
      s = g ? bus.i_req1_select : bus.i_req0_select;
      a = g ? bus.i_req1_data1  : bus.i_req0_data1;
      b = g ? bus.i_req1_data2  : bus.i_req0_data2;
      last_g = g; e_sel = s; e_d1 = a; e_d2 = b;
      pend = 1; pend_owner = g;
      pend_res = alu_fn(s, a, b); pend_zero = (pend_res == 8'h00);
      pulse_at = n + lat_of(s) + 1;
      next_free = pulse_at;
    end
    n++;
    @(posedge clk);
    #1;
  endtask

  task automatic run_vec(input vec_t v);
    int  acc_n;
    bit  got;
    drive_idle();
    drive_req(v.who, v.sel, v.a, v.b);
    got = 0; acc_n = 0;
    for (int c = 0; c < 12 && !got; c++) begin
      cycle();
      if (v.who ? acc1 : acc0) begin got = 1; acc_n = cur_n; end
    end
    chk("vec_accept", 32'(got), 1);
    drive_idle();
    got = 0;
    for (int c = 0; c < 12 && !got; c++) begin
      cycle();
      if (v.who ? obs_v1 : obs_v0) begin
        got = 1;
        chk("vec_lat",  32'(cur_n - acc_n - 1), 32'(v.lat));
        chk("vec_res",  32'(obs_res), 32'(v.res));
        chk("vec_zero", 32'(obs_zero), 32'(v.zero));
      end
    end
    chk("vec_rsp", 32'(got), 1);
  endtask

  task automatic seq_round_robin();
    int order[$];
    do_reset();
    drive_req(0, 3'b001, 8'h11, 8'h22);
    drive_req(1, 3'b010, 8'h33, 8'h44);
    for (int c = 0; c < 40 && order.size() < 4; c++) begin
      cycle();
      chk("rr_excl", 32'(acc0 && acc1), 0);
      if (acc0) order.push_back(0);
      if (acc1) order.push_back(1);
    end
    chk("rr_count", 32'(order.size()), 4);
    foreach (order[i]) chk("rr_order", 32'(order[i]), 32'(i % 2));
    drive_idle();
    repeat (5) cycle();
  endtask

  task automatic seq_reset_mid_exec();
    bit got;
    do_reset();
    drive_req(0, 3'b100, 8'h07, 8'h06);
    got = 0;
    for (int c = 0; c < 8 && !got; c++) begin
      cycle();
      got = acc0;
    end
    chk("mult_accept", 32'(got), 1);
    drive_idle();
    cycle();
    rst_n = 1'b0;
    #1;
    chk_zero("midrst");
    repeat (3) begin
      @(posedge clk);
      #1;
      chk("midrst_rsp0", 32'(bus.o_rsp0_valid), 0);
      chk("midrst_rsp1", 32'(bus.o_rsp1_valid), 0);
    end
    model_reset();
    rst_n = 1'b1;
    drive_req(1, 3'b010, 8'hF0, 8'h3C);
    cycle();
    chk("rst_reacc", 32'(acc1), 1);
    drive_idle();
    repeat (5) cycle();
  endtask

  task automatic seq_single_slow();
    int accs[$];
    bit bh[$];
    int lows;
    do_reset();
    drive_req(1, 3'b101, 8'h40, 8'h01);
    for (int c = 0; c < 22; c++) begin
      cycle();
      bh.push_back(obs_busy);
      if (acc1) accs.push_back(cur_n);
    end
    chk("slow_count", 32'(accs.size() >= 5), 1);
    for (int i = 1; i < accs.size(); i++) begin
      chk("slow_period", 32'(accs[i] - accs[i-1]), 4);
      lows = 0;
      for (int j = accs[i-1] + 1; j <= accs[i]; j++) if (!bh[j]) lows++;
      chk("slow_idle1", 32'(lows), 1);
    end
    drive_idle();
    repeat (5) cycle();
  endtask

  task automatic random_traffic(input int cycles);
    for (int c = 0; c < cycles; c++) begin
      if ($urandom_range(0, 2) == 0) begin
        bus.i_req0_valid  = ($urandom_range(0, 9) < 6);
        bus.i_req0_select = 3'($urandom_range(0, 7));
        bus.i_req0_data1  = 8'($urandom);
        bus.i_req0_data2  = 8'($urandom);
      end
      if ($urandom_range(0, 2) == 0) begin
        bus.i_req1_valid  = ($urandom_range(0, 9) < 6);
        bus.i_req1_select = 3'($urandom_range(0, 7));
        bus.i_req1_data1  = 8'($urandom);
        bus.i_req1_data2  = 8'($urandom);
      end
      cycle();
    end
    drive_idle();
    repeat (6) cycle();
  endtask

  initial begin
    vecs[0] = '{who: 1'b0, sel: 3'b001, a: 8'h05, b: 8'h03, res: 8'h08, zero: 1'b0, lat: 3};
    vecs[1] = '{who: 1'b1, sel: 3'b010, a: 8'hF0, b: 8'h3C, res: 8'h30, zero: 1'b0, lat: 2};
    vecs[2] = '{who: 1'b0, sel: 3'b001, a: 8'h05, b: 8'hFB, res: 8'h00, zero: 1'b1, lat: 3};
    vecs[3] = '{who: 1'b1, sel: 3'b000, a: 8'h5A, b: 8'hC3, res: 8'h5A, zero: 1'b0, lat: 2};
    vecs[4] = '{who: 1'b0, sel: 3'b100, a: 8'h07, b: 8'h06, res: 8'h2A, zero: 1'b0, lat: 3};
    vecs[5] = '{who: 1'b1, sel: 3'b011, a: 8'h0F, b: 8'h30, res: 8'h3F, zero: 1'b0, lat: 2};

    model_reset();
    do_reset();
    foreach (vecs[i]) run_vec(vecs[i]);
    seq_round_robin();
    seq_reset_mid_exec();
    seq_single_slow();
    do_reset();
    random_traffic(600);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
